// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture path.
// Latency: none (constants only).
// Backpressure: none.
// Contents: active-low glyph patterns {g,f,e,d,c,b,a} for hex 0..F,
// the blank glyph, and segment bit positions on the 8-bit segment bus.
package seg7_pkg;

   // Segment bit positions on the {dp,g,f,e,d,c,b,a} bus
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low glyphs, same table the display decoder drives
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_capture_if.sv
// Display-bus observation interface: pins in, reconstructed display state out.
// Latency: none (wiring only).
// Backpressure: none; the display bus is free-running.
// master: drives clear/an/seg, observes results. slave: the capture block.
interface seg7_capture_if #(
   parameter int DIGITS = 8
);
   logic                  clear;
   logic [DIGITS-1:0]     an;
   logic [7:0]            seg;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_out;
   logic [DIGITS-1:0]     digit_valid;
   logic                  bad_pattern;
   logic                  frame_done;

   modport master (
      output clear, an, seg,
      input  value, dp_out, digit_valid, bad_pattern, frame_done
   );

   modport slave (
      input  clear, an, seg,
      output value, dp_out, digit_valid, bad_pattern, frame_done
   );
endinterface

// File: rtl/seg7_encoder.sv
// Glyph-to-nibble encoder: inverse of the hex-to-seven-segment decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: glyph_i (active-low {g..a}), valid_o (hex glyph), blank_o (all off),
// nibble_o (hex value, 0 when not valid).
module seg7_encoder
   import seg7_pkg::*;
(
   input  logic [6:0] glyph_i,
   output logic       valid_o,
   output logic       blank_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      valid_o  = 1'b1;
      blank_o  = 1'b0;
      nibble_o = 4'h0;
      case (glyph_i)
         GLYPH_0: nibble_o = 4'h0;
         GLYPH_1: nibble_o = 4'h1;
         GLYPH_2: nibble_o = 4'h2;
         GLYPH_3: nibble_o = 4'h3;
         GLYPH_4: nibble_o = 4'h4;
         GLYPH_5: nibble_o = 4'h5;
         GLYPH_6: nibble_o = 4'h6;
         GLYPH_7: nibble_o = 4'h7;
         GLYPH_8: nibble_o = 4'h8;
         GLYPH_9: nibble_o = 4'h9;
         GLYPH_A: nibble_o = 4'hA;
         GLYPH_B: nibble_o = 4'hB;
         GLYPH_C: nibble_o = 4'hC;
         GLYPH_D: nibble_o = 4'hD;
         GLYPH_E: nibble_o = 4'hE;
         GLYPH_F: nibble_o = 4'hF;
         SEG_BLANK: begin
            valid_o = 1'b0;
            blank_o = 1'b1;
         end
         default: valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Reconstructs hex digits, decimal points and validity from a multiplexed active-low display bus.
// Latency: outputs update SETTLE+2 edges after new pin values are first registered.
// Backpressure: none; dwells shorter than SETTLE+2 edges are ignored.
// Ports: clk, rst (async, active-high), bus (slave): clear/an/seg in;
// value/dp_out/digit_valid out, bad_pattern/frame_done one-cycle pulses.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int SETTLE = 4
)(
   input  logic           clk,
   input  logic           rst,
   seg7_capture_if.slave  bus
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   logic [DIGITS-1:0]   an_q, an_p_q;
   logic [7:0]          seg_q, seg_p_q;
   logic [3:0]          cnt_q, cnt_d;
   logic                sampled_q, sampled_d;
   logic [4*DIGITS-1:0] value_q, value_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
   logic [DIGITS-1:0]   valid_q, valid_d;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic                bad_q, bad_d;
   logic                frame_q, frame_d;

   logic [DIGITS-1:0]   sel_oh;
   logic                onehot;
   logic                stable;
   logic                sample;
   logic                enc_valid;
   logic                enc_blank;
   logic [3:0]          enc_nib;

   seg7_encoder u_enc (
      .glyph_i  (seg_q[6:0]),
      .valid_o  (enc_valid),
      .blank_o  (enc_blank),
      .nibble_o (enc_nib)
   );

   // Selected digit as a positive one-hot vector
   assign sel_oh = ~an_q;
   assign onehot = $onehot(sel_oh);
   assign stable = ({an_q, seg_q} == {an_p_q, seg_p_q});
   // Stability is re-checked here so a pin change on the sampling edge never
   // pairs a new anode with an old count.
   assign sample = stable && (cnt_q == SETTLE_C) && !sampled_q && onehot;

   always_comb begin
      cnt_d     = cnt_q;
      sampled_d = sampled_q;
      value_d   = value_q;
      dp_d      = dp_q;
      valid_d   = valid_q;
      mask_d    = mask_q;
      bad_d     = 1'b0;
      frame_d   = 1'b0;

      if (!stable) begin
         cnt_d     = 4'd0;
         sampled_d = 1'b0;
      end else if (cnt_q != SETTLE_C) begin
         cnt_d = cnt_q + 4'd1;
      end

      if (sample) begin
         sampled_d = 1'b1;
         for (int i = 0; i < DIGITS; i++) begin
            if (sel_oh[i]) begin
               if (enc_valid) begin
                  value_d[4*i +: 4] = enc_nib;
                  valid_d[i]        = 1'b1;
                  dp_d[i]           = ~seg_q[SEG_DP];
                  mask_d[i]         = 1'b1;
               end else if (enc_blank) begin
                  valid_d[i] = 1'b0;
                  dp_d[i]    = ~seg_q[SEG_DP];
                  mask_d[i]  = 1'b1;
               end else begin
                  valid_d[i] = 1'b0;
               end
            end
         end
         bad_d = !enc_valid && !enc_blank;
         // Mask never rests at all-ones, so completion only fires on the
         // sample that fills the last hole.
         if (&mask_d) begin
            frame_d = 1'b1;
            mask_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q      <= '0;
         seg_q     <= '0;
         an_p_q    <= '0;
         seg_p_q   <= '0;
         cnt_q     <= '0;
         sampled_q <= 1'b0;
         value_q   <= '0;
         dp_q      <= '0;
         valid_q   <= '0;
         mask_q    <= '0;
         bad_q     <= 1'b0;
         frame_q   <= 1'b0;
      end else if (bus.clear) begin
         an_q      <= '0;
         seg_q     <= '0;
         an_p_q    <= '0;
         seg_p_q   <= '0;
         cnt_q     <= '0;
         sampled_q <= 1'b0;
         value_q   <= '0;
         dp_q      <= '0;
         valid_q   <= '0;
         mask_q    <= '0;
         bad_q     <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         an_q      <= bus.an;
         seg_q     <= bus.seg;
         an_p_q    <= an_q;
         seg_p_q   <= seg_q;
         cnt_q     <= cnt_d;
         sampled_q <= sampled_d;
         value_q   <= value_d;
         dp_q      <= dp_d;
         valid_q   <= valid_d;
         mask_q    <= mask_d;
         bad_q     <= bad_d;
         frame_q   <= frame_d;
      end
   end

   assign bus.value       = value_q;
   assign bus.dp_out      = dp_q;
   assign bus.digit_valid = valid_q;
   assign bus.bad_pattern = bad_q;
   assign bus.frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with hand-computed expectations.
// Latency: checks outputs #1 after each rising edge.
// Backpressure: none.
module tb_seg7_capture;

   logic clk;
   logic rst;

   seg7_capture_if #(.DIGITS(8)) bus ();

   seg7_capture #(.DIGITS(8), .SETTLE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      int pulses;
      int pulse_digit;
      int pulse_cycle;
      int extra;
      logic [31:0] word;
      logic [3:0]  nib;

      rst       = 1'b1;
      bus.clear = 1'b0;
      bus.an    = 8'hFF;
      bus.seg   = 8'hFF;
      repeat (3) tick();
      chk("rst_value", bus.value, 32'h0);
      chk("rst_valid", {24'h0, bus.digit_valid}, 32'h0);
      chk("rst_dp", {24'h0, bus.dp_out}, 32'h0);
      chk("rst_pulses", {30'h0, bus.bad_pattern, bus.frame_done}, 32'h0);
      rst = 1'b0;

      // Blank anodes: nothing may be sampled
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.bad_pattern || bus.frame_done || bus.digit_valid != 8'h00) extra++;
      end
      chk("idle_no_pulse", extra, 0);

      // Digit 2 shows '2', dp off; update exactly at edge 6
      bus.an  = 8'hFB;
      bus.seg = 8'hA4;
      repeat (6) tick();
      chk("s2_edge5_value", bus.value, 32'h0);
      chk("s2_edge5_valid", {24'h0, bus.digit_valid}, 32'h0);
      tick();
      chk("s2_edge6_value", bus.value, 32'h0000_0200);
      chk("s2_edge6_valid", {24'h0, bus.digit_valid}, 32'h04);
      chk("s2_edge6_dp", {24'h0, bus.dp_out}, 32'h00);
      repeat (3) tick();

      // Digit 0 shows '9' with dp lit
      bus.an  = 8'hFE;
      bus.seg = 8'h10;
      repeat (8) tick();
      chk("s3_value", bus.value, 32'h0000_0209);
      chk("s3_dp", {24'h0, bus.dp_out}, 32'h01);
      chk("s3_valid", {24'h0, bus.digit_valid}, 32'h05);

      // Short dwell of '1' on digit 0 must not land
      bus.seg = 8'hF9;
      repeat (4) tick();
      bus.an  = 8'hFF;
      bus.seg = 8'hFF;
      repeat (10) tick();
      chk("s3_short_value", bus.value, 32'h0000_0209);
      chk("s3_short_dp", {24'h0, bus.dp_out}, 32'h01);

      // Unrecognised glyph on digit 0
      bus.an  = 8'hFE;
      bus.seg = 8'h7E;
      repeat (6) tick();
      chk("s4_bad_early", {31'h0, bus.bad_pattern}, 32'h0);
      tick();
      chk("s4_bad_pulse", {31'h0, bus.bad_pattern}, 32'h1);
      chk("s4_valid", {24'h0, bus.digit_valid}, 32'h04);
      chk("s4_value", bus.value, 32'h0000_0209);
      chk("s4_dp", {24'h0, bus.dp_out}, 32'h01);
      tick();
      chk("s4_bad_drop", {31'h0, bus.bad_pattern}, 32'h0);
      repeat (4) tick();

      // Two full scans of 1234ABCD
      word = 32'h1234_ABCD;
      for (int pass = 0; pass < 2; pass++) begin
         pulses      = 0;
         pulse_digit = -1;
         pulse_cycle = -1;
         for (int d = 0; d < 8; d++) begin
            nib     = 4'((word >> (4 * d)) & 32'hF);
            bus.an  = ~(8'h01 << d);
            bus.seg = {1'b1, glyph_tbl[nib]};
            for (int c = 0; c < 8; c++) begin
               tick();
               if (bus.frame_done) begin
                  pulses++;
                  pulse_digit = d;
                  pulse_cycle = c;
               end
            end
         end
         chk("s5_frame_count", pulses, 1);
         chk("s5_frame_digit", pulse_digit, 7);
         chk("s5_frame_cycle", pulse_cycle, 6);
         chk("s5_value", bus.value, 32'h1234_ABCD);
         chk("s5_valid", {24'h0, bus.digit_valid}, 32'hFF);
         chk("s5_dp", {24'h0, bus.dp_out}, 32'h00);
      end

      // Two anodes low: ignored
      bus.an  = 8'hFC;
      bus.seg = 8'hC0;
      extra   = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.bad_pattern || bus.frame_done) extra++;
      end
      chk("s6_multi_pulses", extra, 0);
      chk("s6_multi_value", bus.value, 32'h1234_ABCD);
      chk("s6_multi_valid", {24'h0, bus.digit_valid}, 32'hFF);

      // Clear coinciding with a pending sample wins
      bus.an  = 8'hFD;
      bus.seg = 8'hA4;
      repeat (6) tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("clr_value", bus.value, 32'h0);
      chk("clr_valid", {24'h0, bus.digit_valid}, 32'h0);
      chk("clr_dp", {24'h0, bus.dp_out}, 32'h0);
      chk("clr_pulses", {30'h0, bus.bad_pattern, bus.frame_done}, 32'h0);

      // Capture resumes after clear
      repeat (10) tick();
      chk("clr_recap_value", bus.value, 32'h0000_0020);
      chk("clr_recap_valid", {24'h0, bus.digit_valid}, 32'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
